ctrl_unit_pipe: RTL and testbench

CTRL_UNIT_PIPE -- requirements
Module: ctrl_unit_pipe

---
 rtl/ctrl_unit_pipe.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ctrl_unit_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: decode-to-EX control unit for a 5-stage MIPS-style pipe.
// Decodes the instruction in decode, registers the EX control word, tracks an
// in-flight multiply (MULT) and resolves branches one cycle after issue (BR).
// Optional feature: define CTRL_UNIT_GPIO_EN to map srl/sra with shamt 0 onto
// GPIO write/read enables; undefined, those decode as plain shifts.
module ctrl_unit_pipe #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned ALU_OP_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [31:0]         instr_in,
    input  logic                zero_EX,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [4:0]          shamt_EX,
    output logic                enhilo_EX,
    output logic                regwrite_EX,
    output logic                rdrt_EX,
    output logic                memwrite_EX,
    output logic [1:0]          regsel_EX,
    output logic [1:0]          alu_src_EX,
    output logic                gpio_out_EX,
    output logic                gpio_in_EX,
    output logic                pc_src_EX,
    output logic                stall_FETCH,
    output logic                busy_o
);

    typedef enum logic [1:0] {S_RUN, S_MULT, S_BR} state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [4:0] shamt;
        logic       enhilo;
        logic       regwrite;
        logic       rdrt;
        logic       memwrite;
        logic [1:0] regsel;
        logic [1:0] alu_src;
    } ex_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       br_bne_q, br_bne_d;
    logic       pc_src_q, pc_src_d;
    ex_t        ex_q, ex_d;

    ex_t        dec;
    logic       dec_ok, dec_mult, dec_hazard, dec_br, dec_bne;
    logic [5:0] opcode, funct;
    logic [4:0] sh;
    logic       taken, flush, mult_pend, accept;

`ifdef CTRL_UNIT_GPIO_EN
    logic dec_gpio_out, dec_gpio_in;
    logic gpio_out_d, gpio_in_d, gpio_out_q, gpio_in_q;
`endif

    assign opcode = instr_in[31:26];
    assign funct  = instr_in[5:0];
    assign sh     = instr_in[10:6];

    // Instruction decode: control word for the decode-stage instruction.
    always_comb begin
        dec        = '0;
        dec_ok     = 1'b0;
        dec_mult   = 1'b0;
        dec_hazard = 1'b0;
        dec_br     = 1'b0;
        dec_bne    = 1'b0;
`ifdef CTRL_UNIT_GPIO_EN
        dec_gpio_out = 1'b0;
        dec_gpio_in  = 1'b0;
`endif
        if (instr_in != '0) begin
            case (opcode)
                6'b000000: begin
                    dec_ok       = 1'b1;
                    dec.regwrite = 1'b1;
                    case (funct)
                        6'b100000, 6'b100001: dec.op = 4'b0100;
                        6'b100010, 6'b100011: dec.op = 4'b0101;
                        6'b100100: dec.op = 4'b0000;
                        6'b100101: dec.op = 4'b0001;
                        6'b100110: dec.op = 4'b0011;
                        6'b100111: dec.op = 4'b0010;
                        6'b101010: dec.op = 4'b1100;
                        6'b101011: dec.op = 4'b1101;
                        6'b000000: begin
                            dec.op    = 4'b1000;
                            dec.shamt = sh;
                        end
                        6'b000010: begin
                            dec.op    = 4'b1001;
                            dec.shamt = sh;
`ifdef CTRL_UNIT_GPIO_EN
                            if (sh == 5'd0) begin
                                dec_gpio_out = 1'b1;
                                dec.regwrite = 1'b0;
                            end
`endif
                        end
                        6'b000011: begin
                            dec.op    = 4'b1010;
                            dec.shamt = sh;
`ifdef CTRL_UNIT_GPIO_EN
                            if (sh == 5'd0) begin
                                dec_gpio_in = 1'b1;
                                dec.regsel  = 2'd1;
                            end
`endif
                        end
                        6'b010000: begin
                            dec.op     = 4'b1000;
                            dec.regsel = 2'd1;
                            dec_hazard = 1'b1;
                        end
                        6'b010010: begin
                            dec.op     = 4'b1000;
                            dec.regsel = 2'd2;
                            dec_hazard = 1'b1;
                        end
                        6'b011000, 6'b011001: begin
                            dec.op       = funct[0] ? 4'b0111 : 4'b0110;
                            dec.regwrite = 1'b0;
                            dec.enhilo   = 1'b1;
                            dec_mult     = 1'b1;
                            dec_hazard   = 1'b1;
                        end
                        default: dec_ok = 1'b0;
                    endcase
                end
                6'b001000, 6'b001001, 6'b001100, 6'b001101,
                6'b001110, 6'b001010, 6'b001111: begin
                    dec_ok       = 1'b1;
                    dec.rdrt     = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.alu_src  = 2'd2;
                    case (opcode)
                        6'b001000, 6'b001001: begin
                            dec.op      = 4'b0100;
                            dec.alu_src = 2'd1;
                        end
                        6'b001100: dec.op = 4'b0000;
                        6'b001101: dec.op = 4'b0001;
                        6'b001110: dec.op = 4'b0011;
                        6'b001010: begin
                            dec.op      = 4'b1100;
                            dec.alu_src = 2'd1;
                        end
                        default: begin
                            dec.op    = 4'b1000;
                            dec.shamt = 5'd16;
                        end
                    endcase
                end
                6'b101011: begin
                    dec_ok       = 1'b1;
                    dec.op       = 4'b0100;
                    dec.alu_src  = 2'd1;
                    dec.memwrite = 1'b1;
                end
                6'b100011: begin
                    dec_ok       = 1'b1;
                    dec.op       = 4'b0100;
                    dec.alu_src  = 2'd1;
                    dec.rdrt     = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.regsel   = 2'd3;
                end
                6'b000100, 6'b000101: begin
                    dec_ok  = 1'b1;
                    dec.op  = 4'b0101;
                    dec_br  = 1'b1;
                    dec_bne = opcode[0];
                end
                default: dec_ok = 1'b0;
            endcase
        end
    end

    // Hazard/flush resolution, next-state logic and the EX control word.
    // The multiply counter runs independently of the state so that a branch
    // issued during a multiply does not lose the remaining latency.
    always_comb begin
        taken       = (state_q == S_BR) && (br_bne_q ? !zero_EX : zero_EX);
        flush       = taken;
        mult_pend   = (state_q == S_MULT) || (cnt_q != 4'd0);
        stall_FETCH = valid_in && dec_hazard && mult_pend && !flush;
        accept      = valid_in && !stall_FETCH && !flush && dec_ok;

        ex_d     = accept ? dec : '0;
        pc_src_d = taken;
`ifdef CTRL_UNIT_GPIO_EN
        gpio_out_d = accept && dec_gpio_out;
        gpio_in_d  = accept && dec_gpio_in;
`endif

        cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        if (accept && dec_mult) begin
            cnt_d = MULT_LOAD;
        end

        br_bne_d = br_bne_q;
        if (accept && dec_br) begin
            state_d  = S_BR;
            br_bne_d = dec_bne;
        end else if (cnt_d != 4'd0) begin
            state_d = S_MULT;
        end else begin
            state_d = S_RUN;
        end
    end

    // State, counter and EX output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_RUN;
            cnt_q    <= 4'd0;
            br_bne_q <= 1'b0;
            pc_src_q <= 1'b0;
            ex_q     <= '0;
`ifdef CTRL_UNIT_GPIO_EN
            gpio_out_q <= 1'b0;
            gpio_in_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            br_bne_q <= br_bne_d;
            pc_src_q <= pc_src_d;
            ex_q     <= ex_d;
`ifdef CTRL_UNIT_GPIO_EN
            gpio_out_q <= gpio_out_d;
            gpio_in_q  <= gpio_in_d;
`endif
        end
    end

    assign alu_op      = ALU_OP_W'(ex_q.op);
    assign shamt_EX    = ex_q.shamt;
    assign enhilo_EX   = ex_q.enhilo;
    assign regwrite_EX = ex_q.regwrite;
    assign rdrt_EX     = ex_q.rdrt;
    assign memwrite_EX = ex_q.memwrite;
    assign regsel_EX   = ex_q.regsel;
    assign alu_src_EX  = ex_q.alu_src;
    assign pc_src_EX   = pc_src_q;
    assign busy_o      = (state_q == S_MULT);
`ifdef CTRL_UNIT_GPIO_EN
    assign gpio_out_EX = gpio_out_q;
    assign gpio_in_EX  = gpio_in_q;
`else
    assign gpio_out_EX = 1'b0;
    assign gpio_in_EX  = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Directed bench for ctrl_unit_pipe: expected EX words are queued when an
// instruction is driven and popped/compared one clock later.
module tb_ctrl_unit_pipe;

    typedef struct packed {
        logic [3:0] op;
        logic [4:0] shamt;
        logic       enhilo;
        logic       regwrite;
        logic       rdrt;
        logic       memwrite;
        logic [1:0] regsel;
        logic [1:0] alu_src;
        logic       gpio_out;
        logic       gpio_in;
        logic       pc_src;
    } ex_t;

    localparam logic [31:0] ADD   = 32'h012A4020;
    localparam logic [31:0] SUB   = 32'h012A4022;
    localparam logic [31:0] AND_  = 32'h012A4024;
    localparam logic [31:0] OR_   = 32'h012A4025;
    localparam logic [31:0] XOR_  = 32'h012A4026;
    localparam logic [31:0] NOR_  = 32'h012A4027;
    localparam logic [31:0] SLT   = 32'h012A402A;
    localparam logic [31:0] SLTU  = 32'h012A402B;
    localparam logic [31:0] SLL   = 32'h000A4080;
    localparam logic [31:0] SRL   = 32'h000A40C2;
    localparam logic [31:0] SRA   = 32'h000A4103;
    localparam logic [31:0] SRL0  = 32'h000A4002;
    localparam logic [31:0] SRA0  = 32'h000A4003;
    localparam logic [31:0] ADDI  = 32'h21280005;
    localparam logic [31:0] ANDI  = 32'h31280005;
    localparam logic [31:0] ORI   = 32'h35280005;
    localparam logic [31:0] XORI  = 32'h39280005;
    localparam logic [31:0] SLTI  = 32'h29280005;
    localparam logic [31:0] LUI   = 32'h3C081234;
    localparam logic [31:0] LW    = 32'h8D280004;
    localparam logic [31:0] SW    = 32'hAD280004;
    localparam logic [31:0] BAD   = 32'hFC000000;
    localparam logic [31:0] MULT  = 32'h012A0018;
    localparam logic [31:0] MULTU = 32'h012A0019;
    localparam logic [31:0] MFHI  = 32'h00004010;
    localparam logic [31:0] MFLO  = 32'h00004012;
    localparam logic [31:0] BNE   = 32'h152A0003;
    localparam logic [31:0] BEQ   = 32'h112A0003;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] instr_in = '0;
    logic        zero_EX = 1'b0;
    logic [3:0]  alu_op;
    logic [4:0]  shamt_EX;
    logic        enhilo_EX, regwrite_EX, rdrt_EX, memwrite_EX;
    logic [1:0]  regsel_EX, alu_src_EX;
    logic        gpio_out_EX, gpio_in_EX, pc_src_EX, stall_FETCH, busy_o;

    ex_t         sb[$];
    int unsigned tests = 0;
    int unsigned fails = 0;

    ctrl_unit_pipe #(.MULT_CYCLES(4), .ALU_OP_W(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .instr_in(instr_in),
        .zero_EX(zero_EX), .alu_op(alu_op), .shamt_EX(shamt_EX),
        .enhilo_EX(enhilo_EX), .regwrite_EX(regwrite_EX), .rdrt_EX(rdrt_EX),
        .memwrite_EX(memwrite_EX), .regsel_EX(regsel_EX), .alu_src_EX(alu_src_EX),
        .gpio_out_EX(gpio_out_EX), .gpio_in_EX(gpio_in_EX), .pc_src_EX(pc_src_EX),
        .stall_FETCH(stall_FETCH), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    function automatic ex_t mk(input logic [3:0] op, input logic [1:0] src,
                               input logic rw, input logic rdrt,
                               input logic [1:0] regsel, input logic [4:0] sh);
        ex_t e;
        e         = '0;
        e.op      = op;
        e.alu_src = src;
        e.regwrite = rw;
        e.rdrt    = rdrt;
        e.regsel  = regsel;
        e.shamt   = sh;
        return e;
    endfunction

    function automatic ex_t obs();
        return {alu_op, shamt_EX, enhilo_EX, regwrite_EX, rdrt_EX, memwrite_EX,
                regsel_EX, alu_src_EX, gpio_out_EX, gpio_in_EX, pc_src_EX};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
        tests++;
        assert (o === x) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, x);
        end
    endtask

    // Drive one decode cycle, check the combinational flags, queue the
    // expected EX word and compare it after the clock edge.
    task automatic cyc(input string tag, input logic v, input logic [31:0] ins,
                       input logic z, input logic x_stall, input logic x_busy,
                       input ex_t x);
        ex_t e;
        valid_in = v;
        instr_in = ins;
        zero_EX  = z;
        #1;
        chk({tag, ".stall"}, 32'(stall_FETCH), 32'(x_stall));
        chk({tag, ".busy"}, 32'(busy_o), 32'(x_busy));
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s.queue: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".ex"}, 32'(obs()), 32'(e));
        end
    endtask

    initial begin
        ex_t e;
        ex_t br_w;
        ex_t mflo_w;
        ex_t add_w;
        add_w  = mk(4'b0100, 2'd0, 1'b1, 1'b0, 2'd0, 5'd0);
        mflo_w = mk(4'b1000, 2'd0, 1'b1, 1'b0, 2'd2, 5'd0);
        br_w   = mk(4'b0101, 2'd0, 1'b0, 1'b0, 2'd0, 5'd0);

        // reset state
        valid_in = 1'b1;
        instr_in = ADD;
        #12;
        chk("reset.ex", 32'(obs()), 32'd0);
        chk("reset.stall", 32'(stall_FETCH), 32'd0);
        chk("reset.busy", 32'(busy_o), 32'd0);
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // R-type
        cyc("add", 1, ADD, 0, 0, 0, add_w);
        cyc("nop", 1, 32'h0, 0, 0, 0, '0);
        cyc("sub", 1, SUB, 0, 0, 0, mk(4'b0101, 0, 1, 0, 0, 0));
        cyc("and", 1, AND_, 0, 0, 0, mk(4'b0000, 0, 1, 0, 0, 0));
        cyc("or", 1, OR_, 0, 0, 0, mk(4'b0001, 0, 1, 0, 0, 0));
        cyc("xor", 1, XOR_, 0, 0, 0, mk(4'b0011, 0, 1, 0, 0, 0));
        cyc("nor", 1, NOR_, 0, 0, 0, mk(4'b0010, 0, 1, 0, 0, 0));
        cyc("slt", 1, SLT, 0, 0, 0, mk(4'b1100, 0, 1, 0, 0, 0));
        cyc("sltu", 1, SLTU, 0, 0, 0, mk(4'b1101, 0, 1, 0, 0, 0));
        cyc("sll", 1, SLL, 0, 0, 0, mk(4'b1000, 0, 1, 0, 0, 5'd2));
        cyc("srl", 1, SRL, 0, 0, 0, mk(4'b1001, 0, 1, 0, 0, 5'd3));
        cyc("sra", 1, SRA, 0, 0, 0, mk(4'b1010, 0, 1, 0, 0, 5'd4));
        cyc("mfhi", 1, MFHI, 0, 0, 0, mk(4'b1000, 0, 1, 0, 2'd1, 0));
        cyc("invalid", 0, ADD, 0, 0, 0, '0);
        // I-type and memory
        cyc("addi", 1, ADDI, 0, 0, 0, mk(4'b0100, 2'd1, 1, 1, 0, 0));
        cyc("andi", 1, ANDI, 0, 0, 0, mk(4'b0000, 2'd2, 1, 1, 0, 0));
        cyc("ori", 1, ORI, 0, 0, 0, mk(4'b0001, 2'd2, 1, 1, 0, 0));
        cyc("xori", 1, XORI, 0, 0, 0, mk(4'b0011, 2'd2, 1, 1, 0, 0));
        cyc("slti", 1, SLTI, 0, 0, 0, mk(4'b1100, 2'd1, 1, 1, 0, 0));
        cyc("lui", 1, LUI, 0, 0, 0, mk(4'b1000, 2'd2, 1, 1, 0, 5'd16));
        cyc("lw", 1, LW, 0, 0, 0, mk(4'b0100, 2'd1, 1, 1, 2'd3, 0));
        e = mk(4'b0100, 2'd1, 0, 0, 0, 0);
        e.memwrite = 1'b1;
        cyc("sw", 1, SW, 0, 0, 0, e);
        cyc("bad", 1, BAD, 0, 0, 0, '0);

        // GPIO shift-by-zero encodings
`ifdef CTRL_UNIT_GPIO_EN
        e = mk(4'b1001, 0, 0, 0, 0, 0);
        e.gpio_out = 1'b1;
        cyc("srl0", 1, SRL0, 0, 0, 0, e);
        e = mk(4'b1010, 0, 1, 0, 2'd1, 0);
        e.gpio_in = 1'b1;
        cyc("sra0", 1, SRA0, 0, 0, 0, e);
`else
        cyc("srl0", 1, SRL0, 0, 0, 0, mk(4'b1001, 0, 1, 0, 0, 0));
        cyc("sra0", 1, SRA0, 0, 0, 0, mk(4'b1010, 0, 1, 0, 0, 0));
`endif

        // mult then mflo: three stall cycles, mflo issues on the fourth
        e = mk(4'b0110, 0, 0, 0, 0, 0);
        e.enhilo = 1'b1;
        cyc("mult", 1, MULT, 0, 0, 0, e);
        cyc("mflo.s1", 1, MFLO, 0, 1, 1, '0);
        cyc("mflo.s2", 1, MFLO, 0, 1, 1, '0);
        cyc("mflo.s3", 1, MFLO, 0, 1, 1, '0);
        cyc("mflo.go", 1, MFLO, 0, 0, 0, mflo_w);

        // multu: unrelated instructions proceed while busy
        e = mk(4'b0111, 0, 0, 0, 0, 0);
        e.enhilo = 1'b1;
        cyc("multu", 1, MULTU, 0, 0, 0, e);
        cyc("mu.add1", 1, ADD, 0, 0, 1, add_w);
        cyc("mu.add2", 1, ADD, 0, 0, 1, add_w);
        cyc("mu.add3", 1, ADD, 0, 0, 1, add_w);
        cyc("mu.add4", 1, ADD, 0, 0, 0, add_w);

        // bne taken: pc_src pulse and squash
        e = '0;
        e.pc_src = 1'b1;
        cyc("bne.t", 1, BNE, 0, 0, 0, br_w);
        cyc("bne.t.sq", 1, ADD, 0, 0, 0, e);
        cyc("bne.t.nx", 1, ADD, 0, 0, 0, add_w);
        // bne not taken: no squash
        cyc("bne.n", 1, BNE, 1, 0, 0, br_w);
        cyc("bne.n.nx", 1, ADD, 1, 0, 0, add_w);
        cyc("bne.n.nop", 1, 32'h0, 0, 0, 0, '0);
        // beq taken
        cyc("beq.t", 1, BEQ, 1, 0, 0, br_w);
        cyc("beq.t.sq", 1, SUB, 1, 0, 0, e);
        cyc("beq.t.nop", 1, 32'h0, 0, 0, 0, '0);

        // branch during multiply: squash wins over stall, counter keeps running
        e = mk(4'b0110, 0, 0, 0, 0, 0);
        e.enhilo = 1'b1;
        cyc("mb.mult", 1, MULT, 0, 0, 0, e);
        cyc("mb.beq", 1, BEQ, 0, 0, 1, br_w);
        e = '0;
        e.pc_src = 1'b1;
        cyc("mb.sq", 1, MFLO, 1, 0, 0, e);
        cyc("mb.stall", 1, MFLO, 0, 1, 1, '0);
        cyc("mb.mflo", 1, MFLO, 0, 0, 0, mflo_w);

        // reset while the multiply counter is at 2
        e = mk(4'b0110, 0, 0, 0, 0, 0);
        e.enhilo = 1'b1;
        cyc("rm.mult", 1, MULT, 0, 0, 0, e);
        cyc("rm.add", 1, ADD, 0, 0, 1, add_w);
        valid_in = 1'b1;
        instr_in = MFLO;
        #1;
        chk("rm.pre.stall", 32'(stall_FETCH), 32'd1);
        chk("rm.pre.busy", 32'(busy_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("rm.rst.ex", 32'(obs()), 32'd0);
        chk("rm.rst.stall", 32'(stall_FETCH), 32'd0);
        chk("rm.rst.busy", 32'(busy_o), 32'd0);
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rm.post.ex", 32'(obs()), 32'd0);
        cyc("rm.mflo", 1, MFLO, 0, 0, 0, mflo_w);

        // reset in BR with a taken condition: no pc_src afterwards
        cyc("rb.bne", 1, BNE, 0, 0, 0, br_w);
        valid_in = 1'b1;
        instr_in = ADD;
        zero_EX  = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("rb.rst.ex", 32'(obs()), 32'd0);
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rb.post.ex", 32'(obs()), 32'd0);
        cyc("rb.add", 1, ADD, 0, 0, 0, add_w);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
